// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
//
// Capture buffer for the debug block. Each rising edge of `start` snapshots
// the {p_c, d_c} bus pair into a small first-word-fall-through FIFO. Stored
// pairs drain through a valid/ready port. A trigger that arrives while the
// buffer is full, with no pop in the same cycle, is dropped. Dropped
// triggers set a sticky overflow flag and bump a saturating 8-bit counter.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 2)
//   W          width of each captured bus
//
// Ports
//   clk        system clock, rising edge
//   res        synchronous active-high reset
//   start      capture trigger; only its rising edge captures
//   p_c, d_c   buses sampled on a capture
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_pc     head entry p_c field (0 when empty)
//   out_dc     head entry d_c field (0 when empty)
//   count      entries currently held
//   full       count == DEPTH
//   overflow   sticky: at least one trigger dropped since reset
//   drop_cnt   dropped-trigger count, saturates at 255
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       start,
    input  logic [W-1:0]               p_c,
    input  logic [W-1:0]               d_c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_pc,
    output logic [W-1:0]               out_dc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage: each entry holds {p_c, d_c}. Contents are never reset; the
    // count alone decides what is valid.
    logic [2*W-1:0] mem [DEPTH];

    logic          start_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          trig;
    logic          empty;
    logic          is_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [2*W-1:0] head;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == CW'(DEPTH));

    // Rising-edge detect: a held `start` produces a single capture.
    assign trig = start & ~start_q;

    // A pop only occurs when there is something to pop.
    assign pop  = ~empty & out_ready;

    // When full, a same-cycle pop frees the slot the push needs.
    assign push = trig & (~is_full | pop);
    assign drop = trig & is_full & ~pop;

    // Next-state logic
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (res) begin
            start_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            start_q    <= start;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage write. Reset must win over a same-cycle push, so the write is
    // gated; a stray write would be harmless but is kept out for clarity.
    always_ff @(posedge clk) begin
        if (!res && push) begin
            mem[wr_ptr_q] <= {p_c, d_c};
        end
    end

    // First-word-fall-through head: read asynchronously so a captured entry
    // is visible on the outputs right after the edge that wrote it.
    assign head = mem[rd_ptr_q];

    assign out_valid = ~empty;
    assign out_pc    = empty ? '0 : head[2*W-1:W];
    assign out_dc    = empty ? '0 : head[W-1:0];
    assign count     = count_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
